// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock chamber pressure controller:
// state encodings, default sizing constants and the door-closed helper.
package airlock_pkg;

  typedef enum logic [2:0] {
    ST_EVACUATED    = 3'd0,
    ST_PRESSURIZING = 3'd1,
    ST_PRESSURIZED  = 3'd2,
    ST_EVACUATING   = 3'd3,
    ST_HOLD         = 3'd4,
    ST_SETTLE       = 3'd5
  } state_t;

  localparam int DEFAULT_FULL_LEVEL    = 8;
  localparam int DEFAULT_SETTLE_CYCLES = 3;

  function automatic logic doors_closed(input logic inner, input logic outer);
    return !inner && !outer;
  endfunction

endpackage

// File: rtl/airlock_settle_timer.sv
// Load/count-down timer: load presets it, enable counts it down to zero,
// done is high while the count is zero.
module airlock_settle_timer #(
  parameter int CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Loaded with CYCLES-1 so the owner spends exactly CYCLES cycles waiting.
  localparam logic [CW-1:0] LOAD_VAL = CW'((CYCLES > 0) ? CYCLES - 1 : 0);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/airlock_pump_ctrl.sv
// Airlock chamber pump/vent sequencer with door interlock and bounded level counter.
// Optional post-pump settle phase is compiled in with AIRLOCK_PUMP_SETTLE_EN.
module airlock_pump_ctrl
  import airlock_pkg::*;
#(
  parameter int FULL_LEVEL    = DEFAULT_FULL_LEVEL,
  parameter int LEVEL_W       = 4,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pressReq,
  input  logic               evacReq,
  input  logic               innerDoor,
  input  logic               outerDoor,
  output logic               pressurized,
  output logic               evacuated,
  output logic               busy,
  output logic               fault,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         debugState
);

  localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(FULL_LEVEL);

  state_t             state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic               closed, press_ok, evac_ok;
  logic               settle_done;

`ifdef AIRLOCK_PUMP_SETTLE_EN
  localparam bit SettleEn = 1'b1;
  logic settle_load;

  assign settle_load = (state_next == ST_SETTLE) && (state_reg != ST_SETTLE);

  airlock_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (settle_load),
    .enable (state_reg == ST_SETTLE),
    .done   (settle_done)
  );
`else
  localparam bit SettleEn = 1'b0;
  assign settle_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_EVACUATED;
      level_reg <= '0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    closed     = doors_closed(innerDoor, outerDoor);
    press_ok   = pressReq && !evacReq && closed;
    evac_ok    = evacReq && !pressReq && closed;

    case (state_reg)
      ST_EVACUATED: begin
        if (press_ok) state_next = ST_PRESSURIZING;
      end
      ST_PRESSURIZED: begin
        if (evac_ok) state_next = ST_EVACUATING;
      end
      ST_PRESSURIZING: begin
        // Interlock and reversal take the edge; the level is held on it.
        if (!closed) begin
          state_next = ST_HOLD;
        end else if (evac_ok) begin
          state_next = ST_EVACUATING;
        end else if (level_reg >= FULL - 1'b1) begin
          level_next = FULL;
          state_next = SettleEn ? ST_SETTLE : ST_PRESSURIZED;
        end else begin
          level_next = level_reg + 1'b1;
        end
      end
      ST_EVACUATING: begin
        if (!closed) begin
          state_next = ST_HOLD;
        end else if (press_ok) begin
          state_next = ST_PRESSURIZING;
        end else if (level_reg <= LEVEL_W'(1)) begin
          level_next = '0;
          state_next = SettleEn ? ST_SETTLE : ST_EVACUATED;
        end else begin
          level_next = level_reg - 1'b1;
        end
      end
      ST_HOLD: begin
        if (press_ok) begin
          state_next = ST_PRESSURIZING;
        end else if (evac_ok) begin
          state_next = ST_EVACUATING;
        end
      end
      ST_SETTLE: begin
        // The level sits at its target here, so it tells which way we were going.
        if (!closed) begin
          state_next = ST_HOLD;
        end else if (level_reg == FULL && evac_ok) begin
          state_next = ST_EVACUATING;
        end else if (level_reg != FULL && press_ok) begin
          state_next = ST_PRESSURIZING;
        end else if (settle_done) begin
          state_next = (level_reg == FULL) ? ST_PRESSURIZED : ST_EVACUATED;
        end
      end
      default: begin
        state_next = ST_EVACUATED;
        level_next = '0;
      end
    endcase
  end

  assign pressurized = (state_reg == ST_PRESSURIZED);
  assign evacuated   = (state_reg == ST_EVACUATED);
  assign busy        = (state_reg == ST_PRESSURIZING) || (state_reg == ST_EVACUATING) ||
                       (state_reg == ST_SETTLE);
  assign fault       = (state_reg == ST_HOLD);
  assign level       = level_reg;
  assign debugState  = state_reg;

endmodule

// File: tb/tb_airlock_pump_ctrl.sv
// Directed self-checking bench for airlock_pump_ctrl (FULL_LEVEL=8, SETTLE_CYCLES=3);
// also valid with AIRLOCK_PUMP_SETTLE_EN defined.
module tb_airlock_pump_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pressReq = 1'b0;
  logic       evacReq = 1'b0;
  logic       innerDoor = 1'b0;
  logic       outerDoor = 1'b0;
  logic       pressurized, evacuated, busy, fault;
  logic [3:0] level;
  logic [2:0] debugState;

  int n_checks = 0;
  int n_errors = 0;

  airlock_pump_ctrl #(
    .FULL_LEVEL    (8),
    .LEVEL_W       (4),
    .SETTLE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pressReq    (pressReq),
    .evacReq     (evacReq),
    .innerDoor   (innerDoor),
    .outerDoor   (outerDoor),
    .pressurized (pressurized),
    .evacuated   (evacuated),
    .busy        (busy),
    .fault       (fault),
    .level       (level),
    .debugState  (debugState)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then land on the following falling edge to sample.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Single-cycle request pulse sampled at the next rising edge.
  task automatic pulse(input logic p, input logic e);
    pressReq = p;
    evacReq  = e;
    @(posedge clk);
    #1;
    pressReq = 1'b0;
    evacReq  = 1'b0;
    @(negedge clk);
    $display("req press=%0b evac=%0b doors=%0b%0b -> state=%0d level=%0d",
             p, e, innerDoor, outerDoor, debugState, level);
  endtask

  // With the settle phase built in, SETTLE is visible for three cycles after target.
  task automatic settle_tail();
`ifdef AIRLOCK_PUMP_SETTLE_EN
    for (int i = 0; i < 3; i++) begin
      check_val("settle_state", int'(debugState), 5);
      check_val("settle_busy", int'(busy), 1);
      step(1);
    end
`endif
  endtask

  initial begin
    // Reset and its output values
    step(2);
    check_val("rst_evacuated", int'(evacuated), 1);
    check_val("rst_level", int'(level), 0);
    rst = 1'b1;
    step(1);
    check_val("rst_state", int'(debugState), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_fault", int'(fault), 0);
    check_val("rst_pressurized", int'(pressurized), 0);

    // Illegal and no-effect requests in EVACUATED
    pulse(1'b1, 1'b1);
    check_val("both_req_state", int'(debugState), 0);
    pulse(1'b0, 1'b1);
    check_val("evac_in_evac_state", int'(debugState), 0);
    outerDoor = 1'b1;
    pulse(1'b1, 1'b0);
    check_val("press_door_open_state", int'(debugState), 0);
    outerDoor = 1'b0;

    // Full pressurize from 0
    pulse(1'b1, 1'b0);
    check_val("press_busy", int'(busy), 1);
    check_val("press_state", int'(debugState), 1);
    check_val("press_level0", int'(level), 0);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check_val($sformatf("press_level%0d", i), int'(level), i);
      if (i < 8) check_val("press_pumping", int'(debugState), 1);
    end
    settle_tail();
    check_val("press_done", int'(pressurized), 1);
    check_val("press_done_state", int'(debugState), 2);
    check_val("press_done_busy", int'(busy), 0);

    // Ignored requests in PRESSURIZED
    pulse(1'b1, 1'b0);
    check_val("press_in_press", int'(debugState), 2);
    innerDoor = 1'b1;
    pulse(1'b0, 1'b1);
    check_val("evac_door_open_state", int'(debugState), 2);
    check_val("evac_door_open_fault", int'(fault), 0);
    innerDoor = 1'b0;

    // Evacuate partway then reverse to pressurize
    pulse(1'b0, 1'b1);
    check_val("evac_state", int'(debugState), 3);
    step(3);
    check_val("evac_level5", int'(level), 5);
    pulse(1'b1, 1'b0);
    check_val("rev_up_state", int'(debugState), 1);
    check_val("rev_up_level", int'(level), 5);
    step(3);
    check_val("rev_up_level8", int'(level), 8);
    settle_tail();
    check_val("rev_up_done", int'(pressurized), 1);

    // Full evacuate from FULL_LEVEL
    pulse(1'b0, 1'b1);
    step(7);
    check_val("evac_level1", int'(level), 1);
    check_val("evac_not_done", int'(evacuated), 0);
    step(1);
    check_val("evac_level0", int'(level), 0);
    settle_tail();
    check_val("evac_done", int'(evacuated), 1);

    // Interlock at level 3, hold, resume
    pulse(1'b1, 1'b0);
    step(3);
    check_val("il_level3", int'(level), 3);
    outerDoor = 1'b1;
    step(1);
    check_val("il_fault", int'(fault), 1);
    check_val("il_state", int'(debugState), 4);
    check_val("il_level_frozen", int'(level), 3);
    outerDoor = 1'b0;
    step(2);
    check_val("il_close_only", int'(debugState), 4);
    check_val("il_close_level", int'(level), 3);
    innerDoor = 1'b1;
    pulse(1'b1, 1'b0);
    check_val("il_req_door_open", int'(debugState), 4);
    innerDoor = 1'b0;
    pulse(1'b1, 1'b0);
    check_val("il_resume_fault", int'(fault), 0);
    check_val("il_resume_state", int'(debugState), 1);
    step(4);
    check_val("il_level7", int'(level), 7);
    check_val("il_not_yet", int'(pressurized), 0);
    step(1);
    check_val("il_level8", int'(level), 8);
    settle_tail();
    check_val("il_pressurized", int'(pressurized), 1);

    // Evacuate back, then pressurize to 4 and reverse
    pulse(1'b0, 1'b1);
    step(8);
    settle_tail();
    check_val("rev_pre_evac", int'(evacuated), 1);
    pulse(1'b1, 1'b0);
    step(4);
    check_val("rev_level4", int'(level), 4);
    pulse(1'b0, 1'b1);
    check_val("rev_state", int'(debugState), 3);
    check_val("rev_level_hold", int'(level), 4);
    for (int i = 3; i >= 0; i--) begin
      step(1);
      check_val($sformatf("rev_level%0d", i), int'(level), i);
    end
    settle_tail();
    check_val("rev_evacuated", int'(evacuated), 1);

    // Asynchronous reset mid-run
    pulse(1'b1, 1'b0);
    step(2);
    check_val("arst_pre_level", int'(level), 2);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_level", int'(level), 0);
    check_val("arst_evacuated", int'(evacuated), 1);
    check_val("arst_state", int'(debugState), 0);
    check_val("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    check_val("arst_after_level", int'(level), 0);
    pulse(1'b1, 1'b0);
    check_val("arst_first_req", int'(debugState), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/airlock_pump_ctrl.md
# airlock_pump_ctrl

Chamber pressure controller for the airlock. It runs the pump and vent sequencing that produces the `pressurized` and `evacuated` status signals consumed by the arriving and departing sequencer FSMs. It accepts single-cycle pressurize/evacuate requests from those sequencers and models the chamber level with a bounded up/down counter. A door interlock freezes pumping whenever either door is open.

## Interface
Parameters:
- FULL_LEVEL, 8: chamber level at full pressure; also the pump cycles from vacuum to full.
- LEVEL_W, 4: level counter width; FULL_LEVEL must fit in this width.
- SETTLE_CYCLES, 3: settle delay in cycles; used only when the settle feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pressReq  in  1  pressurize request, single-cycle pulse.
- evacReq  in  1  evacuate request, single-cycle pulse.
- innerDoor  in  1  1 = inner door open.
- outerDoor  in  1  1 = outer door open.
- pressurized  out  1  high in state PRESSURIZED.
- evacuated  out  1  high in state EVACUATED.
- busy  out  1  high in state PRESSURIZING, EVACUATING or SETTLE.
- fault  out  1  high in state HOLD.
- level  out  LEVEL_W  current chamber level.
- debugState  out  3  state encoding.

## Operation
- States and encodings: EVACUATED=0, PRESSURIZING=1, PRESSURIZED=2, EVACUATING=3, HOLD=4, SETTLE=5.
- All outputs are decoded from registered state and level.
- "Doors closed" means innerDoor=0 and outerDoor=0.
- A request is "valid" when exactly one of pressReq/evacReq is high and the doors are closed.
- If both requests are high in the same cycle, the cycle is ignored in every state.
- EVACUATED, valid pressReq: go to PRESSURIZING.
- EVACUATED, evacReq or any door activity: no effect.
- PRESSURIZED, valid evacReq: go to EVACUATING.
- PRESSURIZED, pressReq: ignored.
- PRESSURIZED, evacReq with a door open: ignored; fault stays 0.
- PRESSURIZING, each cycle with doors closed: level += 1.
  - When level == FULL_LEVEL-1: level <= FULL_LEVEL and state <= PRESSURIZED (or SETTLE).
- EVACUATING: mirror of PRESSURIZING.
  - Level −1 per cycle; on reaching 0, go to EVACUATED (or SETTLE).
- Reversal: valid evacReq in PRESSURIZING goes to EVACUATING next edge, decrementing from the current level. Valid pressReq in EVACUATING reverses the same way.
- Same-direction request while pumping: ignored.
- Interlock: either door open during PRESSURIZING/EVACUATING goes to HOLD at the next edge.
  - Level is frozen on that edge; no increment happens.
- HOLD: a valid request resumes the requested direction from the frozen level and clears fault.
  - Door closure alone does not resume.
  - Requests while a door is still open are ignored.
- Level saturates: never below 0, never above FULL_LEVEL.

## Timing
- Reset (rst=0), asynchronous:
  - state=EVACUATED, level=0.
  - evacuated=1; pressurized=0, busy=0, fault=0, debugState=0.
- Reset mid-operation aborts immediately to these values. The first request is accepted on the first rising edge with rst=1.
- Latency, request sampled at edge k:
  - busy goes high after edge k.
  - A full pressurize from 0 asserts pressurized after edge k+FULL_LEVEL.
  - A full evacuate from FULL_LEVEL asserts evacuated after edge k+FULL_LEVEL.
- Partial runs: a run starting from level L takes FULL_LEVEL−L cycles (pressurize) or L cycles (evacuate).
- Door opening at edge j: fault is high after edge j, and level holds its edge j−1 value.

## Configuration
- Macro: AIRLOCK_PUMP_SETTLE_EN.
- Defined:
  - When the target level is reached, go to SETTLE; busy stays 1.
  - Hold SETTLE_CYCLES cycles, then go to PRESSURIZED or EVACUATED; status asserts SETTLE_CYCLES cycles later than without the macro.
  - A door opening in SETTLE goes to HOLD with level at target; a valid request resumes.
  - A reversal request in SETTLE starts pumping the opposite way.
- Undefined:
  - SETTLE is unreachable; status asserts the edge the level reaches target.
  - The SETTLE_CYCLES parameter is unused.

## Structure
- Shared package airlock_pkg holds:
  - state encodings (3-bit);
  - default FULL_LEVEL and SETTLE_CYCLES constants;
  - the door-closed helper function.
- One sub-module, airlock_settle_timer: a load/count-down timer with a done flag. Instantiate it only under AIRLOCK_PUMP_SETTLE_EN.
- Next-state logic and the level counter live in the top module.

## Test plan
All scenarios use FULL_LEVEL=8 and the macro undefined unless noted.
- Reset: rst=0 asynchronously mid-cycle → immediately evacuated=1, level=0, debugState=0, busy=0, fault=0.
- Full pressurize: pressReq pulse at edge k → busy=1 after k; level 1..8 over edges k+1..k+8; pressurized=1 and debugState=2 after k+8.
- Interlock: outerDoor=1 when level=3 → fault=1, debugState=4, level stays 3. Close the door alone → still HOLD. pressReq → pressurized after 5 more edges; fault=0.
- Reversal: pressReq, then after level=4 an evacReq → level 3,2,1,0 on the next 4 edges; evacuated=1.
- Illegal requests: pressReq=evacReq=1 in EVACUATED → no change. evacReq in PRESSURIZED with innerDoor=1 → no change, fault=0.
- AIRLOCK_PUMP_SETTLE_EN defined, SETTLE_CYCLES=3: full pressurize → debugState=5 for 3 cycles after level=8, then pressurized=1 at edge k+11.
